// File: rtl/aes_frame_sequencer.sv
// Serialises plaintext/size/key into the encrypt-slave byte frame via the SPI master, then collects 16 ciphertext bytes.
// Latency: first byte_start 1 cycle after an accepted start; next exchange BYTE_GAP cycles after each byte_done; done 1 cycle after the last rx byte.
// Backpressure: paced by byte_done/result_ready; start_enc while busy is dropped. Optional WAIT_RES timeout under SEQ_TIMEOUT_EN.
module aes_frame_sequencer #(
    parameter int unsigned BYTE_GAP = 1,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_enc,
    input  logic [1:0]   key_size_sel,
    input  logic [127:0] plain_text,
    input  logic [255:0] key,
    output logic         byte_start,
    output logic [7:0]   byte_tx,
    input  logic [7:0]   byte_rx,
    input  logic         byte_done,
    input  logic         result_ready,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] result
);

    if (BYTE_GAP < 1 || BYTE_GAP > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("aes_frame_sequencer: BYTE_GAP or TIMEOUT out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE, S_ERR} state_t;

    localparam logic [3:0] GAP_RELOAD = 4'(BYTE_GAP - 1);

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [3:0]     gap_q, gap_d;
    logic           out_q, out_d;
    logic           start_q, start_d;
    logic [7:0]     tx_q, tx_d;
    logic [127:0]   pt_q, pt_d;
    logic [255:0]   key_q, key_d;
    logic [5:0]     ks_q, ks_d;
    logic [127:0]   result_q, result_d;
    logic           ierr_q, ierr_d;
    logic           dn;
    logic           issue;
    logic [5:0]     ks_in;
`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]    tmo_q, tmo_d;
`endif

    // r = exchanges still owed in the frame, so key bytes come out as key[8r-1 -: 8].
    function automatic logic [7:0] frame_byte(input logic [127:0] pt, input logic [255:0] k,
                                              input logic [5:0] ks, input logic [5:0] r);
        logic [7:0] b;
        logic [5:0] pos;
        b   = 8'h00;
        pos = ks + 6'd17 - r;
        if (r == ks + 6'd1) begin
            b = {2'b00, ks};
        end else if (r <= ks) begin
            for (int i = 0; i < 32; i++) if (r == 6'(i + 1)) b = k[8*i +: 8];
        end else begin
            for (int i = 0; i < 16; i++) if (pos == 6'(i)) b = pt[8*(15-i) +: 8];
        end
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        out_d    = out_q;
        start_d  = 1'b0;
        tx_d     = tx_q;
        pt_d     = pt_q;
        key_d    = key_q;
        ks_d     = ks_q;
        result_d = result_q;
        ierr_d   = 1'b0;
        issue    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        dn    = byte_done & out_q;
        ks_in = (key_size_sel == 2'b01) ? 6'd24 : (key_size_sel == 2'b10) ? 6'd32 : 6'd16;
        if (dn) out_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_enc && !byte_done) begin
                    if (key_size_sel == 2'b11) begin
                        ierr_d = 1'b1;
                    end else begin
                        pt_d     = plain_text;
                        key_d    = key;
                        ks_d     = ks_in;
                        result_d = '0;
                        cnt_d    = ks_in + 6'd17;
                        state_d  = S_SEND;
                        issue    = 1'b1;
                    end
                end
            end
            S_SEND, S_RECV: begin
                if (dn) begin
                    if (state_q == S_RECV) begin
                        for (int i = 0; i < 16; i++) if (cnt_q == 6'(i + 1)) result_d[8*i +: 8] = byte_rx;
                    end
                    if (cnt_q == 6'd1) begin
                        state_d = (state_q == S_SEND) ? S_WAIT : S_DONE;
`ifdef SEQ_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                        if (GAP_RELOAD == 4'd0) issue = 1'b1;
                        else                    gap_d = GAP_RELOAD;
                    end
                end else if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q == 4'd1) issue = 1'b1;
                end
            end
            S_WAIT: begin
                if (result_ready) begin
                    state_d = S_RECV;
                    cnt_d   = 6'd16;
                    issue   = 1'b1;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) state_d = S_ERR;
                else                        tmo_d   = tmo_q + 16'd1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            start_d = 1'b1;
            out_d   = 1'b1;
            tx_d    = (state_d == S_SEND) ? frame_byte(pt_d, key_d, ks_d, cnt_d) : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            out_q    <= 1'b0;
            start_q  <= 1'b0;
            tx_q     <= 8'h00;
            pt_q     <= '0;
            key_q    <= '0;
            ks_q     <= '0;
            result_q <= '0;
            ierr_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            out_q    <= out_d;
            start_q  <= start_d;
            tx_q     <= tx_d;
            pt_q     <= pt_d;
            key_q    <= key_d;
            ks_q     <= ks_d;
            result_q <= result_d;
            ierr_q   <= ierr_d;
`ifdef SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign byte_start = start_q;
    assign byte_tx    = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = ierr_q | (state_q == S_ERR);
    assign result     = result_q;

endmodule

// File: tb/tb_aes_frame_sequencer.sv
// Directed bench for aes_frame_sequencer with a behavioural SPI master/encrypt-slave model.
module tb_aes_frame_sequencer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_enc;
    logic [1:0]   key_size_sel;
    logic [127:0] plain_text;
    logic [255:0] key;
    logic         byte_start;
    logic [7:0]   byte_tx;
    logic [7:0]   byte_rx = 8'h00;
    logic         byte_done;
    logic         result_ready = 1'b0;
    logic         busy, done, error;
    logic [127:0] result;
    logic         m_done = 1'b0;
    logic         spur_done;

    assign byte_done = m_done | spur_done;

    always #5 clk = ~clk;

    aes_frame_sequencer #(.BYTE_GAP(1), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .start_enc(start_enc), .key_size_sel(key_size_sel),
        .plain_text(plain_text), .key(key), .byte_start(byte_start), .byte_tx(byte_tx),
        .byte_rx(byte_rx), .byte_done(byte_done), .result_ready(result_ready),
        .busy(busy), .done(done), .error(error), .result(result)
    );

    typedef struct {
        logic [1:0]   sel;
        logic [127:0] pt;
        logic [255:0] key;
        int           len;
        logic [7:0]   size_b;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[3];

    int checks = 0;
    int failures = 0;

    // Model state: written only by the model process; bench controls it via case_id/frame_len/ct_m/rr_en.
    int           case_id = 0, seen_id = 0;
    int           frame_len = 0;
    logic [127:0] ct_m = '0;
    bit           rr_en = 1'b0;
    int           cyc = 0, n_start = 0, n_done = 0, pend = 0, last_done_cyc = 0;
    int           stab_err = 0, gap_err = 0, rx_n = 0;
    logic [7:0]   held_tx = 8'h00;
    logic [7:0]   tx_log[64];

    always @(negedge clk) begin
        cyc    = cyc + 1;
        m_done = 1'b0;
        if (case_id != seen_id) begin
            seen_id = case_id; n_start = 0; n_done = 0; stab_err = 0; gap_err = 0; pend = 0;
        end
        if (!reset) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    if (byte_tx !== held_tx) stab_err++;
                    rx_n = n_done - frame_len;
                    if (rx_n >= 0 && rx_n < 16) byte_rx = ct_m[8*(15-rx_n) +: 8];
                    else                        byte_rx = 8'h5a;
                    m_done        = 1'b1;
                    n_done        = n_done + 1;
                    last_done_cyc = cyc;
                end
            end
            if (byte_start) begin
                if (n_start < 64) tx_log[n_start] = byte_tx;
                if (n_start > 0 && (cyc - last_done_cyc) != ((n_start == frame_len) ? 2 : 1)) gap_err++;
                n_start = n_start + 1;
                held_tx = byte_tx;
                pend    = 3;
            end
        end
        result_ready = rr_en && (n_done >= frame_len);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_case(input vec_t v, input bit retrig, input int id);
        int t, done_t, dones, frame_err;
        logic [7:0] eb;
        case_id = id; frame_len = v.len; ct_m = v.ct; rr_en = 1'b1;
        plain_text = v.pt; key = v.key; key_size_sel = v.sel; start_enc = 1'b1;
        @(posedge clk); #1;
        chk1("first_byte_start", byte_start, 1'b1);
        chk1("busy_after_start", busy, 1'b1);
        chkn("first_byte_tx", 128'(byte_tx), 128'(v.pt[127:120]));
        chkn("result_cleared", result, '0);
        start_enc = 1'b0; plain_text = ~v.pt; key = ~v.key; key_size_sel = 2'b11;
        dones = 0; done_t = -10;
        for (t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            start_enc = retrig && (t == 100);
            if (done) begin
                dones++; done_t = t;
                chk1("busy_during_done", busy, 1'b1);
            end
            if (!busy) break;
        end
        start_enc = 1'b0;
        chk1("busy_end", busy, 1'b0);
        chkn("done_to_idle", 128'(t - done_t), 128'(1));
        chkn("done_count", 128'(dones), 128'(1));
        chkn("start_count", 128'(n_start), 128'(v.len + 16));
        chkn("done_count_model", 128'(n_done), 128'(v.len + 16));
        frame_err = 0;
        for (int i = 0; i < v.len + 16 && i < 64; i++) begin
            if (i < 16)         eb = v.pt[8*(15-i) +: 8];
            else if (i == 16)   eb = v.size_b;
            else if (i < v.len) eb = v.key[8*(v.len-1-i) +: 8];
            else                eb = 8'h00;
            if (tx_log[i] !== eb) frame_err++;
        end
        chkn("frame_bytes", 128'(frame_err), '0);
        chkn("size_byte", 128'(tx_log[16]), 128'(v.size_b));
        chkn("first_key_byte", 128'(tx_log[17]), 128'(v.key[8*(v.len-18) +: 8]));
        chkn("result", result, v.ct);
        chkn("tx_stable", 128'(stab_err), '0);
        chkn("byte_gap", 128'(gap_err), '0);
    endtask

    int t0, t, base;

    initial begin
        vecs[0] = '{sel: 2'b10, pt: 128'h00112233445566778899aabbccddeeff,
                    key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    len: 49, size_b: 8'h20, ct: 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[1] = '{sel: 2'b00, pt: 128'h00112233445566778899aabbccddeeff,
                    key: {{16{8'hee}}, 128'h000102030405060708090a0b0c0d0e0f},
                    len: 33, size_b: 8'h10, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{sel: 2'b01, pt: 128'h00112233445566778899aabbccddeeff,
                    key: {{8{8'hee}}, 192'h000102030405060708090a0b0c0d0e0f1011121314151617},
                    len: 41, size_b: 8'h18, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191};

        start_enc = 1'b0; key_size_sel = 2'b00; plain_text = '0; key = '0; spur_done = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk1("rst_byte_start", byte_start, 1'b0);
        chkn("rst_byte_tx", 128'(byte_tx), '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chkn("rst_result", result, '0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Illegal key size select
        case_id = 1; frame_len = 0; rr_en = 1'b0; key_size_sel = 2'b11; start_enc = 1'b1;
        @(posedge clk); #1;
        start_enc = 1'b0;
        chk1("illegal_error", error, 1'b1);
        chk1("illegal_busy", busy, 1'b0);
        chk1("illegal_byte_start", byte_start, 1'b0);
        @(posedge clk); #1;
        chk1("illegal_error_pulse", error, 1'b0);
        repeat (3) @(posedge clk); #1;
        chkn("illegal_no_start", 128'(n_start), '0);

        // byte_done colliding with start_enc, then a stray byte_done
        key_size_sel = 2'b00; start_enc = 1'b1; spur_done = 1'b1;
        @(posedge clk); #1;
        start_enc = 1'b0; spur_done = 1'b0;
        chk1("collide_busy", busy, 1'b0);
        chk1("collide_byte_start", byte_start, 1'b0);
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        chk1("stray_done_busy", busy, 1'b0);
        @(posedge clk); #1;
        chkn("stray_done_no_start", 128'(n_start), '0);

        for (int i = 0; i < 3; i++) run_case(vecs[i], i == 0, 2 + i);

        // Reset after the 10th TX byte_done
        case_id = 5; frame_len = 49; ct_m = vecs[0].ct; rr_en = 1'b1;
        plain_text = vecs[0].pt; key = vecs[0].key; key_size_sel = 2'b10; start_enc = 1'b1;
        @(posedge clk); #1;
        start_enc = 1'b0;
        for (t = 0; t < 400; t++) begin
            if (n_done >= 10) break;
            @(posedge clk); #1;
        end
        chkn("reset_point", 128'(n_done), 128'(10));
        reset = 1'b0;
        #1;
        chk1("midrst_byte_start", byte_start, 1'b0);
        chkn("midrst_byte_tx", 128'(byte_tx), '0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_error", error, 1'b0);
        chkn("midrst_result", result, '0);
        base = n_start;
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk); #1;
        chkn("midrst_no_start", 128'(n_start), 128'(base));
        run_case(vecs[0], 1'b0, 6);

`ifdef SEQ_TIMEOUT_EN
        case_id = 7; frame_len = 49; ct_m = vecs[0].ct; rr_en = 1'b0;
        plain_text = vecs[0].pt; key = vecs[0].key; key_size_sel = 2'b10; start_enc = 1'b1;
        @(posedge clk); #1;
        start_enc = 1'b0;
        t0 = -1000;
        for (t = 0; t < 1000; t++) begin
            @(posedge clk); #1;
            if (t0 < 0 && n_done >= 49) t0 = t;
            if (error) break;
        end
        chk1("timeout_error", error, 1'b1);
        chkn("timeout_cycles", 128'(t - t0), 128'(100));
        chk1("timeout_busy_at_error", busy, 1'b1);
        chkn("timeout_no_rx", 128'(n_start), 128'(49));
        chkn("timeout_result", result, '0);
        @(posedge clk); #1;
        chk1("timeout_busy_drop", busy, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_frame_sequencer.md
# aes_frame_sequencer

Synthesizable host-side sequencer sitting directly upstream of the SPI `master`. It accepts a 128-bit plaintext, a key and a key-size select from the system, serialises them into the byte frame the `encrypt` slave expects, and drives the master one byte exchange at a time. It waits for the slave's result-ready flag, clocks the 16 ciphertext bytes back out, and presents the assembled 128-bit result with a done pulse.

## Interface
- `BYTE_GAP`, default 1: idle cycles between a `byte_done` and the next `byte_start`. Legal range is 1..15.
- `TIMEOUT`, default 65535: cycle limit for waiting on `result_ready`. Active only with `SEQ_TIMEOUT_EN`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start_enc` input 1: request pulse, sampled only in IDLE.
- `key_size_sel` input 2: 00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = illegal.
- `plain_text` input 128: plaintext, MSB byte sent first.
- `key` input 256: key, right-aligned; the low KS bytes are used.
- `byte_start` output 1: one-cycle pulse that starts an SPI byte exchange.
- `byte_tx` output 8: byte for the master to shift out; held stable from `byte_start` until `byte_done`.
- `byte_rx` input 8: byte received by the master; valid when `byte_done` is high.
- `byte_done` input 1: one-cycle pulse when the master/slave exchange completes.
- `result_ready` input 1: level from the slave (`enc_recived`); ciphertext is available.
- `busy` output 1: high from the accepted start through the done/error cycle.
- `done` output 1: one-cycle pulse; `result` is valid.
- `error` output 1: one-cycle pulse on illegal `key_size_sel` or timeout.
- `result` output 128: assembled ciphertext; holds its value until the next accepted start.

## Operation
- KS = 16, 24 or 32 bytes.
- Send frame, in order:
  - 16 plaintext bytes, `plain_text[127:120]` first.
  - One size byte: 0x10, 0x18 or 0x20.
  - KS key bytes, `key[8*KS-1 -: 8]` first, down to `key[7:0]`.
  - Total TX = 17+KS exchanges: 33, 41 or 49.
- Receive phase: 16 exchanges with `byte_tx`=0x00. Byte n (n=0..15) is captured into `result[127-8n -: 8]`.
- States:
  - IDLE: `start_enc` with legal select latches inputs and goes to SEND. With illegal select, stays in IDLE and pulses `error` (no `byte_start`).
  - SEND: issues frame bytes. When the final key byte's `byte_done` arrives, goes to WAIT_RES.
  - WAIT_RES: when `result_ready` is high, goes to RECV.
  - RECV: issues 16 exchanges. On the 16th `byte_done`, goes to DONE.
  - DONE: pulses `done` for one cycle, then returns to IDLE.
- The byte counter is 6 bits and counts down. It decrements only on `byte_done`, never wraps, and reloads on state entry.
- `plain_text`, `key` and `key_size_sel` are latched at start. Later input changes do not affect the frame in flight.
- `start_enc` while `busy` is ignored; it is not queued.
- A `byte_done` with no outstanding `byte_start` is ignored.
- `result` is cleared to 0 on an accepted start. Partial captures are visible during RECV.
- Reset mid-operation returns to IDLE immediately. No further `byte_start` is issued, and any in-flight exchange is abandoned.

## Timing
- Reset values: `byte_start`=0, `byte_tx`=0x00, `busy`=0, `done`=0, `error`=0, `result`=0; state IDLE.
- `start_enc` high at edge k gives: `busy`=1 and first `byte_start` at edge k+1, with `byte_tx`=`plain_text[127:120]`.
- Illegal select at edge k gives an `error` pulse at edge k+1; `busy` stays 0.
- A `byte_done` at edge j gives the next `byte_start` at edge j+BYTE_GAP. `byte_tx` updates in the same cycle as `byte_start`.
- WAIT_RES to RECV: first RX `byte_start` 1 cycle after `result_ready` is sampled high.
- If `result_ready` is already high on entry to WAIT_RES, WAIT_RES still lasts exactly one cycle.
- Last RX `byte_done` at edge j: `result` is complete at j+1, `done`=1 at j+1, `busy` falls at j+2.
- `byte_done` and `start_enc` in the same cycle: `byte_done` is processed; `start_enc` is ignored.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT_RES.
  - If `result_ready` has not arrived after TIMEOUT cycles, the block pulses `error`, drops `busy` on the next cycle and returns to IDLE; `result` stays 0.
- Not defined: the counter and its logic are absent, and WAIT_RES waits indefinitely.

## Test plan
- AES-256 case:
  - Stimulus: `plain_text`=00112233445566778899aabbccddeeff, `key`=000102…1e1f, sel=10, bench SPI master/slave model.
  - Required response: 49 TX exchanges with the 17th byte 0x20, then 16 RX; `result`=8ea2b7ca516745bfeafc49904b496089, single `done` pulse.
- AES-128 case:
  - Stimulus: same plaintext, `key` low half=000102…0f, sel=00.
  - Required response: 33 TX exchanges with size byte 0x10 and first key byte 0x00; `result`=69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-192 case:
  - Stimulus: `key`=000102…17, sel=01.
  - Required response: 41 TX exchanges, size byte 0x18; `result`=dda97ca4864cdfe06eaf70a0ec0d7191.
- Illegal select and ignored start:
  - Stimulus: sel=11 with `start_enc`. Then, during a busy 256-bit run, assert `start_enc` again.
  - Required response: `error` pulse, zero `byte_start`, `busy`=0. The second `start_enc` is ignored and the TX count stays 49.
- Reset mid-frame:
  - Stimulus: pull `reset` low after the 10th TX `byte_done`.
  - Required response: all outputs at reset values in the same cycle. A fresh start then sends a full 49-byte frame beginning with 0x00.
- Timeout (`SEQ_TIMEOUT_EN`, TIMEOUT=100):
  - Stimulus: hold `result_ready`=0.
  - Required response: `error` exactly 100 cycles after WAIT_RES entry, no RX exchanges, `result`=0.
